program_loader: RTL and testbench

- Byte-stream writer that fills program memory before the core runs.
- Accepts a framed image over a valid/ready byte interface and assembles big-endian 32-bit instructions.
- Issues one-cycle word writes to the instruction store at consecutive word-aligned byte addresses.
- Holds the processor via cpu_hold until a verified image is loaded; sits between the host link (UART/JTAG bridge) and the instruction store.

---
 rtl/program_loader.sv | 173 +++++++++++++++++
 tb/tb_program_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a framed program image over a valid/ready byte link,
//               assembles big-endian words, writes them to the instruction
//               store and holds the core until a checksum-verified image is in.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(MEMORY_DEPTH);

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [15:0]             word_idx_q, word_idx_d;
    logic [7:0]              acc_q, acc_d;
    logic                    mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic                    xfer;
    logic [31:0]             count_full;
    logic [DATA_WIDTH-1:0]   word_offset;
    logic [DATA_WIDTH-1:0]   word_next;

    // Handshake and busy are pure functions of the state.
    always_comb begin
        busy     = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHECK);
        in_ready = busy;
        xfer     = in_valid && in_ready;
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERROR);
        cpu_hold = (state_q != S_DONE);
    end

    // Datapath helpers: full count as seen on the count_lo byte, byte offset
    // of the current word, and the word with the incoming byte shifted in.
    always_comb begin
        count_full  = {16'd0, count_q[15:8], in_byte};
        word_offset = {{(DATA_WIDTH-18){1'b0}}, word_idx_q, 2'b00};
        word_next   = {word_q[DATA_WIDTH-9:0], in_byte};
    end

    // Next-state and register-update logic for the whole frame parser.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        acc_d       = acc_q;
        mem_write_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_CNT_HI;
                    acc_d      = 8'd0;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = in_byte;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = in_byte;
                    if (count_full > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (count_full == 32'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = word_next;
                    acc_d      = acc_q ^ in_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes a word: strobe it out next cycle.
                    if (byte_idx_q == 2'd3) begin
                        mem_write_d = 1'b1;
                        wr_data_d   = word_next;
                        wr_addr_d   = BASE_ADDRESS + word_offset;
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == count_q - 16'd1) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_byte == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 16'd0;
            word_q      <= '0;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= 16'd0;
            acc_q       <= 8'd0;
            mem_write_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            acc_q       <= acc_d;
            mem_write_q <= mem_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Write port driven straight from registers.
    always_comb begin
        MemWrite     = mem_write_q;
        WriteAddress = wr_addr_q;
        WriteData    = wr_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        MemWrite;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int checks;
    int failures;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    program_loader #(
        .MEMORY_DEPTH(32),
        .DATA_WIDTH  (32),
        .BASE_ADDRESS(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .MemWrite    (MemWrite),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_hold    (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen on the store interface.
    always @(negedge clk) begin
        if (MemWrite === 1'b1) begin
            wa_q.push_back(WriteAddress);
            wd_q.push_back(WriteData);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; bounded wait for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent;
        for (int g = 0; g < gap; g++) step();
        in_byte  = b;
        in_valid = 1'b1;
        sent     = 1'b0;
        for (int t = 0; t < 50 && !sent; t++) begin
            if (in_ready === 1'b1) sent = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!sent) begin
            failures++;
            $display("FAIL send_timeout byte=%02h in_ready=%b required=1", b, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({in_ready, busy, done, error, MemWrite} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=00000", {in_ready, busy, done, error, MemWrite});
        end
        checks++;
        if (cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold actual=%b required=1", cpu_hold);
        end
        checks++;
        if (WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
            failures++;
            $display("FAIL reset_wr actual=%h/%h required=0/0", WriteAddress, WriteData);
        end
        // Bytes offered while idle must not be consumed.
        in_byte = 8'h00; in_valid = 1'b1;
        step(); step(); step();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_consume in_ready=%b busy=%b required=0/0", in_ready, busy);
        end
        in_valid = 1'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_arm busy=%b in_ready=%b required=1/1", busy, in_ready);
        end
        // Return to idle for the following tests.
        reset = 1'b1; #1; reset = 1'b0; step();
    endtask

    task automatic test_two_words(input logic [7:0] csum, input bit good);
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        checks++;
        if (MemWrite !== 1'b1 || WriteAddress !== 32'h0 || WriteData !== 32'h2008_0005) begin
            failures++;
            $display("FAIL w0_latency mw=%b addr=%h data=%h required=1/0/20080005", MemWrite, WriteAddress, WriteData);
        end
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h0C, 0);
        send_byte(csum, 0);
        checks++;
        if (wa_q.size() != 2) begin
            failures++;
            $display("FAIL two_count actual=%0d required=2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h2008_0005) begin
                failures++;
                $display("FAIL two_w0 actual=%h/%h required=0/20080005", wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0000_000C) begin
                failures++;
                $display("FAIL two_w1 actual=%h/%h required=4/0000000c", wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if ({done, error, cpu_hold, busy} !== (good ? 4'b1000 : 4'b0110)) begin
            failures++;
            $display("FAIL two_status actual=%b required=%b", {done, error, cpu_hold, busy}, good ? 4'b1000 : 4'b0110);
        end
    endtask

    task automatic test_overflow();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h21, 0);
        checks++;
        if ({error, done, in_ready, busy, cpu_hold} !== 5'b10001) begin
            failures++;
            $display("FAIL ovf_status actual=%b required=10001", {error, done, in_ready, busy, cpu_hold});
        end
        step(); step();
        checks++;
        if (wa_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_writes actual=%0d required=0", wa_q.size());
        end
    endtask

    task automatic test_zero_count(input logic [7:0] csum, input bit good);
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_check_state busy=%b in_ready=%b required=1/1", busy, in_ready);
        end
        send_byte(csum, 1);
        step();
        checks++;
        if ({done, error, cpu_hold} !== (good ? 3'b100 : 3'b011) || wa_q.size() != 0) begin
            failures++;
            $display("FAIL zero_status actual=%b writes=%0d required=%b writes=0",
                     {done, error, cpu_hold}, wa_q.size(), good ? 3'b100 : 3'b011);
        end
    endtask

    task automatic test_reset_midload_then_full();
        logic [7:0] w [0:3];
        logic [7:0] acc;
        pulse_start();
        send_byte(8'h00, 1); send_byte(8'h20, 2);
        send_byte(8'h11, 0); send_byte(8'h22, 2); send_byte(8'h33, 1); send_byte(8'h44, 0);
        send_byte(8'h55, 3); send_byte(8'h66, 1);
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, done, error, MemWrite, cpu_hold} !== 6'b000001 ||
            WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
            failures++;
            $display("FAIL async_reset flags=%b addr=%h data=%h required=000001/0/0",
                     {busy, in_ready, done, error, MemWrite, cpu_hold}, WriteAddress, WriteData);
        end
        reset = 1'b0;
        step();
        wa_q.delete(); wd_q.delete();
        acc = 8'h00;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) begin
            w[0] = 8'(i); w[1] = 8'hA5; w[2] = 8'(i * 3); w[3] = 8'h5A;
            for (int k = 0; k < 4; k++) begin
                acc = acc ^ w[k];
                send_byte(w[k], (i + k) % 3);
            end
        end
        send_byte(acc, 0);
        checks++;
        if (wa_q.size() != 32) begin
            failures++;
            $display("FAIL full_count actual=%0d required=32", wa_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== {8'(i), 8'hA5, 8'(i * 3), 8'h5A}) begin
                    failures++;
                    $display("FAIL full_w%0d actual=%h/%h required=%h/%h", i, wa_q[i], wd_q[i],
                             32'(i * 4), {8'(i), 8'hA5, 8'(i * 3), 8'h5A});
                end
            end
        end
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL full_status actual=%b required=1000", {done, error, cpu_hold, busy});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_two_words(8'h21, 1'b1);
        test_two_words(8'h22, 1'b0);
        test_overflow();
        test_zero_count(8'h00, 1'b1);
        test_zero_count(8'h01, 1'b0);
        test_reset_midload_then_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
